data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Memory-mapped responder for a single-cycle core: word RAM, an 8N1 UART
// transmitter and a free-running timer with a sticky compare flag.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned BAUD_DIV  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        TxOut,
  output logic        TimerIrq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  localparam logic [29:0] TXDATA_WA  = 30'h2000_0000;
  localparam logic [29:0] TIMER_WA   = 30'h2000_0001;
  localparam logic [29:0] TIMECMP_WA = 30'h2000_0002;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Address decode; byte offset bits are don't-care for word accesses
  logic          sel_ram, sel_tx, sel_tim, sel_cmp;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign sel_ram          = (ALUResult[31:AW+2] == '0);
  assign sel_tx           = (ALUResult[31:2] == TXDATA_WA);
  assign sel_tim          = (ALUResult[31:2] == TIMER_WA);
  assign sel_cmp          = (ALUResult[31:2] == TIMECMP_WA);
  assign ram_idx          = ALUResult[AW+1:2];
  assign unused_addr_bits = ^ALUResult[1:0];

  logic [31:0] mem_q [RAM_WORDS];

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) begin
      mem_q[ram_idx] <= WriteData;
    end
  end

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          irq_q, irq_d;
  logic          busy;

  assign busy = (state_q != TX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  // TX next state; line level is derived from the next state so it is registered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (MemWrite && sel_tx) begin
          state_d = TX_START;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          shift_d = WriteData[7:0];
        end
      end
      TX_START: begin
        if (baud_q == '0) begin
          state_d = TX_DATA;
          baud_d  = BAUD_LAST;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Timer, compare register and sticky flag; a compare write beats a match
  always_comb begin
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_q;
    irq_d   = irq_q | (timer_q == cmp_q);
    if (MemWrite && sel_tim) begin
      timer_d = WriteData;
    end
    if (MemWrite && sel_cmp) begin
      cmp_d = WriteData;
      irq_d = 1'b0;
    end
  end

  always_comb begin
    ReadData = '0;
    if (sel_ram) begin
      ReadData = mem_q[ram_idx];
    end else if (sel_tx) begin
      ReadData = {31'b0, busy};
    end else if (sel_tim) begin
      ReadData = timer_q;
    end else if (sel_cmp) begin
      ReadData = cmp_q;
    end
  end

  assign TxOut    = tx_q;
  assign TimerIrq = irq_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: stimulus queues expected values
// tagged with a cycle number, a negedge monitor compares them.
module tb_data_bus_responder;

  localparam logic [31:0] A_TX    = 32'h8000_0000;
  localparam logic [31:0] A_TIMER = 32'h8000_0004;
  localparam logic [31:0] A_CMP   = 32'h8000_0008;

  localparam int K_RD  = 0;
  localparam int K_TX  = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        TxOut;
  logic        TimerIrq;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_chk;
  int          n_pass;
  logic        done;
  logic [31:0] mon_act;

  data_bus_responder #(
    .RAM_WORDS(64),
    .BAUD_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .TxOut    (TxOut),
    .TimerIrq (TimerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  // Monitor: compare every entry due this cycle; drain leftovers at the end
  initial begin
    n_chk  = 0;
    n_pass = 0;
  end

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc || done) begin
        case (sb[i].kind)
          K_RD:    mon_act = ReadData;
          K_TX:    mon_act = {31'b0, TxOut};
          default: mon_act = {31'b0, TimerIrq};
        endcase
        n_chk++;
        if (sb[i].cyc != cyc) begin
          $display("FAIL %s: got no sample at cycle %0d, want check at cycle %0d",
                   sb[i].name, cyc, sb[i].cyc);
        end else if (mon_act === sb[i].exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s (cycle %0d): got %h, want %h",
                   sb[i].name, cyc, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int unsigned ofs, input int kind,
                      input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // One bus cycle, optionally checking ReadData during it
  task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                    input logic chk, input logic [31:0] exp, input string name);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    if (chk) push(0, K_RD, exp, name);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    op(1'b1, addr, wd, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    op(1'b0, addr, 32'h0, 1'b1, exp, name);
  endtask

  // Expected line levels for a frame whose write is accepted this cycle
  task automatic sched_frame(input logic [7:0] b);
    for (int k = 1; k <= 4; k++) push(k, K_TX, 32'd0, "tx_start_bit");
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) push(5 + 4 * i + j, K_TX, {31'b0, b[i]}, "tx_data_bit");
    end
    for (int k = 37; k <= 41; k++) push(k, K_TX, 32'd1, "tx_stop_idle");
  endtask

  task automatic flush_tx();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].kind == K_TX && sb[i].cyc >= cyc) sb.delete(i);
    end
  endtask

  initial begin
    done      = 1'b0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    @(posedge clk);
    #1;

    // Reset values
    push(0, K_TX, 32'd1, "rst_txout");
    push(0, K_IRQ, 32'd0, "rst_irq");
    rd(A_TIMER, 32'h0, "rst_timer");
    rd(A_CMP, 32'hFFFF_FFFF, "rst_timecmp");
    rd(A_TX, 32'h0, "rst_busy");
    reset = 1'b0;
    rd(A_TIMER, 32'h0, "post_rst_timer0");
    rd(A_TIMER, 32'h1, "post_rst_timer1");
    rd(A_TIMER, 32'h2, "post_rst_timer2");

    // RAM and unmapped accesses
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_00FC, 32'h1234_5678);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd_10");
    rd(32'h0000_00FC, 32'h1234_5678, "ram_rd_fc");
    wr(32'h0000_0014, 32'hCAFE_F00D);
    rd(32'h0000_0014, 32'hCAFE_F00D, "ram_rd_after_wr");
    rd(32'h4000_0000, 32'h0, "unmapped_rd");
    rd(32'h8000_000C, 32'h0, "unmapped_rd_io");
    wr(32'h4000_0010, 32'hFFFF_FFFF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "unmapped_wr_ignored");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_offset_ignored");

    // Timer load and wrap; wrapping through TIMECMP reset value raises the flag
    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER, 32'hFFFF_FFFE, "timer_load");
    push(0, K_IRQ, 32'd0, "irq_before_match");
    rd(A_TIMER, 32'hFFFF_FFFF, "timer_max");
    push(0, K_IRQ, 32'd1, "irq_at_wrap_match");
    rd(A_TIMER, 32'h0, "timer_wrap");

    // Compare flag rise, stickiness and clear
    wr(A_TIMER, 32'h0);
    wr(A_CMP, 32'h20);
    push(0, K_IRQ, 32'd0, "irq_cleared_by_cmp_wr");
    wr(A_TIMER, 32'h1E);
    push(0, K_IRQ, 32'd0, "irq_low_1e");
    rd(A_TIMER, 32'h1E, "timer_1e");
    push(0, K_IRQ, 32'd0, "irq_low_1f");
    rd(A_TIMER, 32'h1F, "timer_1f");
    push(0, K_IRQ, 32'd0, "irq_low_at_match");
    rd(A_TIMER, 32'h20, "timer_20");
    push(0, K_IRQ, 32'd1, "irq_rise");
    rd(A_CMP, 32'h20, "timecmp_rd");
    push(0, K_IRQ, 32'd1, "irq_sticky");
    rd(A_TIMER, 32'h22, "timer_22");
    push(0, K_IRQ, 32'd1, "irq_before_clear");
    wr(A_CMP, 32'h100);
    push(0, K_IRQ, 32'd0, "irq_clear");
    rd(A_CMP, 32'h100, "timecmp_rd_100");

    // Set and clear in the same cycle
    wr(A_CMP, 32'h60);
    wr(A_TIMER, 32'h60);
    op(1'b1, A_CMP, 32'h60, 1'b1, 32'h60, "timecmp_rd_during_wr");
    push(0, K_IRQ, 32'd0, "irq_set_clear_same_cycle");
    rd(A_TIMER, 32'h61, "timer_61");
    push(0, K_IRQ, 32'd0, "irq_stays_low");
    rd(A_TIMER, 32'h62, "timer_62");
    wr(A_CMP, 32'h55);

    // Frame 0xA5 with an ignored write mid-frame
    push(0, K_TX, 32'd1, "tx_idle_at_wr");
    sched_frame(8'hA5);
    op(1'b1, A_TX, 32'h0000_00A5, 1'b1, 32'h0, "busy_at_accept");
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) op(1'b1, A_TX, 32'h0000_00FF, 1'b1, 32'h1, "busy_mid_wr");
      else         rd(A_TX, 32'h1, "busy_in_frame");
    end

    // Back-to-back frame accepted in the first idle cycle
    sched_frame(8'h00);
    op(1'b1, A_TX, 32'h0, 1'b1, 32'h0, "busy_first_idle");
    for (int k = 1; k <= 18; k++) rd(A_TX, 32'h1, "busy_frame2");
    wr(A_TIMER, 32'h55);
    rd(A_TIMER, 32'h55, "timer_pre_rst");

    // Asynchronous reset during a data bit, flag set, timer at 0x55
    ALUResult = A_TX;
    #1;
    reset = 1'b1;
    flush_tx();
    push(0, K_RD, 32'h0, "rst_async_busy");
    push(0, K_TX, 32'd1, "rst_async_txout");
    push(0, K_IRQ, 32'd0, "rst_async_irq");
    @(posedge clk);
    #1;
    rd(A_TIMER, 32'h0, "rst_async_timer");
    rd(A_CMP, 32'hFFFF_FFFF, "rst_async_timecmp");
    reset = 1'b0;
    for (int k = 0; k < 45; k++) push(k, K_TX, 32'd1, "no_residual_bits");
    rd(A_TIMER, 32'h0, "rel_timer0");
    rd(A_TIMER, 32'h1, "rel_timer1");
    for (int k = 0; k < 43; k++) rd(A_TX, 32'h0, "rel_busy");

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
